hazard_controller: RTL and testbench
====================================

// Module: hazard_controller
// PURPOSE
//  Obstacle ("barrel") engine that is the consumer of the player's position/size outputs and the
//  sole producer of the player's `colliding` input. Spawns up to NUM_BARRELS barrels at the top
//  tier and rolls them down the six-tier level, alternating direction per tier and falling at the
//  edges. Registers an AABB player/barrel overlap test each frame. Exports barrel positions for
//  the sprite renderer.
// PARAMETERS
//  NUM_BARRELS   4    barrel slots (1..8)
//  SPAWN_PERIOD  120  frames between spawns
//  SPAWN_X       130  x of a new barrel
//  TOP_FLOOR     114  y of tier 0 floor; tier k floor = TOP_FLOOR + k*TIER_H, k=0..5
//  TIER_H        60   tier pitch in px
//  X_LEFT_EDGE   25   left tier edge
//  X_RIGHT_EDGE  615  right tier edge
//  ROLL_STEP     2    px/frame along x while rolling
//  FALL_STEP     3    px/frame along y while falling
//  BARREL_S      16   barrel box size in px
// PORTS
//  frame_clk     in   1              frame-rate clock, all state on rising edge
//  Reset         in   1              asynchronous, active-low reset
//  paused        in   1              player pause status (1 = game frozen)
//  BallX         in   10             player box left x
//  BallY         in   10             player box top y
//  BallS         in   10             player box size
//  colliding     out  1              registered overlap with any active barrel
//  barrel_active out  NUM_BARRELS    per-slot active flag
//  barrel_x      out  10*NUM_BARRELS slot i at [10*i+9:10*i]
//  barrel_y      out  10*NUM_BARRELS slot i at [10*i+9:10*i]
// BEHAVIOUR
//  Reset (Reset==0, async):
//   - all slots IDLE; barrel_active=0; barrel_x=barrel_y=0; colliding=0
//   - spawn counter=0; paused_q=1
//  Per-slot FSM, evaluated once per frame_clk while paused==0:
//   - IDLE:
//     - on spawn: x=SPAWN_X; y=TOP_FLOOR; tier=0; dir=RIGHT; go to ROLL
//   - ROLL: x += ROLL_STEP if dir RIGHT, else x -= ROLL_STEP
//     - edge reached = x+step >= X_RIGHT_EDGE (RIGHT) or x <= X_LEFT_EDGE+step (LEFT)
//     - edge reached on tier<5: x clamped to edge; target=floor(tier+1); go to FALL
//     - edge reached on tier 5: go to IDLE, active=0
//   - FALL: y += FALL_STEP; x unchanged
//     - if y+FALL_STEP >= target: y=target; tier++; dir flips; go to ROLL
//  Direction rule: even tiers roll RIGHT, odd tiers roll LEFT. Tier 5 (y=414) exits left.
//  Spawn counter: increments each unpaused frame up to SPAWN_PERIOD-1, then holds.
//   - at SPAWN_PERIOD-1 with a free slot: lowest-index IDLE slot spawns; counter -> 0
//   - no free slot: counter holds; spawn occurs on first frame a slot is IDLE at clock edge
//     (a slot freed this frame is spawnable next frame, never the same frame)
//  Collision: hit_i = active_i & (bx<px+ps) & (px<bx+BARREL_S) & (by<py+ps) & (py<by+BARREL_S)
//   - compare in 11-bit unsigned, no wrap
//   - colliding <= |hit while paused==0; forced 0 while paused==1; one-frame latency
//   - uses pre-update barrel positions
//  Pause:
//   - paused==1: all slots, positions and counter frozen
//   - falling edge of paused (paused_q=1, paused=0; the resume after Enter): all slots IDLE,
//     counter=0, colliding=0 that frame
//   - motion restarts next frame
// TESTING
//  - Reset low mid-roll -> next sample shows active=0, colliding=0, counter=0,
//    regardless of frame_clk.
//  - paused=0 for 120 frames -> slot0 active at (130,114); 2 frames later x=134.
//  - Slot0 x reaches 615 on tier0 -> FALL: y=117,120,..., lands at y=174; then rolls LEFT
//    (x decreasing by 2).
//  - Barrel on tier5 reaches x<=27 -> active0 drops to 0. With counter already at max,
//    respawn happens one frame later, not the same frame.
//  - Player (BallX=140,BallY=114,BallS=16), barrel at (130,114) -> colliding=1 next frame.
//    Player moved to BallX=146 -> colliding=0 (edge-touch is not a hit).
//  - All 4 slots active at counter max, paused 1->0 -> all slots cleared, no spawn for
//    120 frames, colliding=0.

Source files
------------

// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
//
// Barrel obstacle engine. Spawns up to NUM_BARRELS barrels at the top tier,
// rolls them along six tiers (even tiers roll right, odd tiers roll left),
// drops them at tier edges, and retires them off the left edge of the bottom
// tier. Each frame it registers an axis-aligned box overlap test between the
// player and every active barrel.
//
// Ports
//   frame_clk     in   frame-rate clock; all state updates on the rising edge
//   Reset         in   asynchronous active-low reset
//   paused        in   1 = game frozen; a 1->0 transition clears all barrels
//   BallX/BallY   in   player box top-left corner (px)
//   BallS         in   player box size (px)
//   colliding     out  registered overlap of player with any active barrel
//   barrel_active out  per-slot active flag
//   barrel_x/y    out  per-slot position, slot i at bits [10*i+9:10*i]
// -----------------------------------------------------------------------------
module hazard_controller #(
    parameter int NUM_BARRELS  = 4,
    parameter int SPAWN_PERIOD = 120,
    parameter int SPAWN_X      = 130,
    parameter int TOP_FLOOR    = 114,
    parameter int TIER_H       = 60,
    parameter int X_LEFT_EDGE  = 25,
    parameter int X_RIGHT_EDGE = 615,
    parameter int ROLL_STEP    = 2,
    parameter int FALL_STEP    = 3,
    parameter int BARREL_S     = 16
) (
    input  logic                      frame_clk,
    input  logic                      Reset,
    input  logic                      paused,
    input  logic [9:0]                BallX,
    input  logic [9:0]                BallY,
    input  logic [9:0]                BallS,
    output logic                      colliding,
    output logic [NUM_BARRELS-1:0]    barrel_active,
    output logic [10*NUM_BARRELS-1:0] barrel_x,
    output logic [10*NUM_BARRELS-1:0] barrel_y
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ROLL = 2'd1,
        ST_FALL = 2'd2
    } state_t;

    localparam int CNT_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SPAWN_PERIOD - 1);

    localparam logic [9:0]  P_SPAWN_X = 10'(SPAWN_X);
    localparam logic [9:0]  P_TOP     = 10'(TOP_FLOOR);
    localparam logic [9:0]  P_LEFT    = 10'(X_LEFT_EDGE);
    localparam logic [9:0]  P_RIGHT   = 10'(X_RIGHT_EDGE);
    localparam logic [9:0]  P_ROLL    = 10'(ROLL_STEP);
    localparam logic [9:0]  P_FALL    = 10'(FALL_STEP);
    localparam logic [10:0] P_BS      = 11'(BARREL_S);
    localparam logic [2:0]  LAST_TIER = 3'd5;

    state_t         r_state [NUM_BARRELS];
    logic [9:0]     r_x     [NUM_BARRELS];
    logic [9:0]     r_y     [NUM_BARRELS];
    logic [2:0]     r_tier  [NUM_BARRELS];
    logic           r_dir   [NUM_BARRELS];   // 1 = rolling right
    logic [CNT_W-1:0] r_cnt;
    logic           r_paused_q;
    logic           r_colliding;

    logic [NUM_BARRELS-1:0] w_hit;
    logic [NUM_BARRELS-1:0] w_spawn_sel;
    logic                   w_any_free;
    logic                   w_spawn_go;

    // Floor y of a given tier.
    function automatic logic [9:0] floor_y(input logic [2:0] tier);
        return 10'(TOP_FLOOR + TIER_H * int'(tier));
    endfunction

    // Edge test done in 11 bits so x+step never wraps.
    function automatic logic at_edge(input logic dir_right, input logic [9:0] x);
        if (dir_right)
            return ({1'b0, x} + {1'b0, P_ROLL}) >= {1'b0, P_RIGHT};
        else
            return {1'b0, x} <= ({1'b0, P_LEFT} + {1'b0, P_ROLL});
    endfunction

    // True when the next fall step would reach or pass the landing floor.
    function automatic logic lands(input logic [9:0] y, input logic [9:0] target);
        return ({1'b0, y} + {1'b0, P_FALL}) >= {1'b0, target};
    endfunction

    // Lowest-index idle slot gets the spawn. Uses state at the clock edge, so
    // a slot retiring this frame cannot be refilled until the next frame.
    always_comb begin
        w_spawn_sel = '0;
        w_any_free  = 1'b0;
        for (int i = 0; i < NUM_BARRELS; i++) begin
            if (r_state[i] == ST_IDLE && !w_any_free) begin
                w_spawn_sel[i] = 1'b1;
                w_any_free     = 1'b1;
            end
        end
        w_spawn_go = (r_cnt == CNT_MAX) && w_any_free;
    end

    // Player/barrel overlap on pre-update positions; 11-bit sums avoid wrap.
    always_comb begin
        w_hit = '0;
        for (int i = 0; i < NUM_BARRELS; i++) begin
            w_hit[i] = (r_state[i] != ST_IDLE)
                     && ({1'b0, r_x[i]} < ({1'b0, BallX} + {1'b0, BallS}))
                     && ({1'b0, BallX}  < ({1'b0, r_x[i]} + P_BS))
                     && ({1'b0, r_y[i]} < ({1'b0, BallY} + {1'b0, BallS}))
                     && ({1'b0, BallY}  < ({1'b0, r_y[i]} + P_BS));
        end
    end

    always_ff @(posedge frame_clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < NUM_BARRELS; i++) begin
                r_state[i] <= ST_IDLE;
                r_x[i]     <= '0;
                r_y[i]     <= '0;
                r_tier[i]  <= '0;
                r_dir[i]   <= 1'b1;
            end
            r_cnt       <= '0;
            r_paused_q  <= 1'b1;
            r_colliding <= 1'b0;
        end else begin
            r_paused_q <= paused;
            if (paused) begin
                r_colliding <= 1'b0;
            end else if (r_paused_q) begin
                // Resume after pause: level restarts empty.
                for (int i = 0; i < NUM_BARRELS; i++) begin
                    r_state[i] <= ST_IDLE;
                end
                r_cnt       <= '0;
                r_colliding <= 1'b0;
            end else begin
                r_colliding <= |w_hit;

                if (w_spawn_go)
                    r_cnt <= '0;
                else if (r_cnt != CNT_MAX)
                    r_cnt <= r_cnt + 1'b1;

                for (int i = 0; i < NUM_BARRELS; i++) begin
                    case (r_state[i])
                        ST_IDLE: begin
                            if (w_spawn_go && w_spawn_sel[i]) begin
                                r_x[i]     <= P_SPAWN_X;
                                r_y[i]     <= P_TOP;
                                r_tier[i]  <= '0;
                                r_dir[i]   <= 1'b1;
                                r_state[i] <= ST_ROLL;
                            end
                        end
                        ST_ROLL: begin
                            if (at_edge(r_dir[i], r_x[i])) begin
                                if (r_tier[i] == LAST_TIER) begin
                                    r_state[i] <= ST_IDLE;
                                end else begin
                                    r_x[i]     <= r_dir[i] ? P_RIGHT : P_LEFT;
                                    r_state[i] <= ST_FALL;
                                end
                            end else begin
                                r_x[i] <= r_dir[i] ? (r_x[i] + P_ROLL) : (r_x[i] - P_ROLL);
                            end
                        end
                        ST_FALL: begin
                            if (lands(r_y[i], floor_y(r_tier[i] + 3'd1))) begin
                                r_y[i]     <= floor_y(r_tier[i] + 3'd1);
                                r_tier[i]  <= r_tier[i] + 3'd1;
                                r_dir[i]   <= ~r_dir[i];
                                r_state[i] <= ST_ROLL;
                            end else begin
                                r_y[i] <= r_y[i] + P_FALL;
                            end
                        end
                        default: r_state[i] <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    always_comb begin
        barrel_active = '0;
        barrel_x      = '0;
        barrel_y      = '0;
        for (int i = 0; i < NUM_BARRELS; i++) begin
            barrel_active[i]     = (r_state[i] != ST_IDLE);
            barrel_x[10*i +: 10] = r_x[i];
            barrel_y[10*i +: 10] = r_y[i];
        end
    end

    assign colliding = r_colliding;

endmodule

// File: tb/tb_hazard_controller.sv
// -----------------------------------------------------------------------------
// tb_hazard_controller
//
// Scoreboard bench for hazard_controller. Expected values are queued with the
// frame number at which they must hold; a monitor on the falling clock edge
// pops and compares every entry due at the current frame. Frame number =
// rising edges since Reset was released.
// -----------------------------------------------------------------------------
module tb_hazard_controller;

    localparam int NB = 4;

    logic            frame_clk = 1'b0;
    logic            Reset;
    logic            paused;
    logic [9:0]      BallX, BallY, BallS;
    logic            colliding;
    logic [NB-1:0]   barrel_active;
    logic [10*NB-1:0] barrel_x, barrel_y;

    hazard_controller #(.NUM_BARRELS(NB)) dut (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .paused       (paused),
        .BallX        (BallX),
        .BallY        (BallY),
        .BallS        (BallS),
        .colliding    (colliding),
        .barrel_active(barrel_active),
        .barrel_x     (barrel_x),
        .barrel_y     (barrel_y)
    );

    always #5 frame_clk = ~frame_clk;

    int frame_cnt;
    always @(posedge frame_clk or negedge Reset) begin
        if (!Reset) frame_cnt <= 0;
        else        frame_cnt <= frame_cnt + 1;
    end

    localparam int K_ACT = 0, K_X = 1, K_Y = 2, K_COL = 3;

    typedef struct {
        int    frame;
        int    kind;
        int    slot;
        int    val;
        string name;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   done     = 1'b0;

    task automatic expect_at(input int f, input int k, input int s, input int v, input string nm);
        exp_t e;
        e.frame = f; e.kind = k; e.slot = s; e.val = v; e.name = nm;
        sb.push_back(e);
    endtask

    function automatic int actual(input int k, input int s);
        case (k)
            K_ACT:   return int'(barrel_active);
            K_X:     return int'(barrel_x[10*s +: 10]);
            K_Y:     return int'(barrel_y[10*s +: 10]);
            default: return int'(colliding);
        endcase
    endfunction

    // Monitor: compare everything due at this frame.
    exp_t m_e;
    int   m_act;
    always @(negedge frame_clk) begin
        while (sb.size() > 0 && sb[0].frame == frame_cnt) begin
            m_e   = sb.pop_front();
            m_act = actual(m_e.kind, m_e.slot);
            n_checks++;
            if (m_act != m_e.val) begin
                n_fail++;
                $display("FAIL %s (frame %0d, slot %0d): got %0d, expected %0d",
                         m_e.name, m_e.frame, m_e.slot, m_act, m_e.val);
            end
        end
    end

    task automatic wait_frame(input int f);
        while (frame_cnt != f) @(negedge frame_clk);
        #1;
    endtask

    task automatic set_ball(input int x, input int y, input int s);
        BallX = 10'(x); BallY = 10'(y); BallS = 10'(s);
    endtask

    task automatic expect_reset_state();
        expect_at(0, K_ACT, 0, 0, "reset_active");
        expect_at(0, K_COL, 0, 0, "reset_colliding");
        for (int i = 0; i < NB; i++) begin
            expect_at(0, K_X, i, 0, "reset_x");
            expect_at(0, K_Y, i, 0, "reset_y");
        end
    endtask

    initial begin
        Reset  = 1'b0;
        paused = 1'b0;
        set_ball(0, 0, 1);

        // ---- expectations, in frame order per reset epoch ----
        expect_reset_state();
        // first spawn: edge 1 is the post-reset resume, then 119 counts
        expect_at(120, K_ACT, 0, 4'b0000, "no_spawn_before_period");
        expect_at(121, K_ACT, 0, 4'b0001, "first_spawn_active");
        expect_at(121, K_X,   0, 130,     "spawn_x");
        expect_at(121, K_Y,   0, 114,     "spawn_y");
        expect_at(122, K_COL, 0, 1,       "coll_overlap");
        expect_at(123, K_X,   0, 134,     "roll_right_x");
        expect_at(123, K_COL, 0, 0,       "coll_touch_right_side");
        expect_at(124, K_COL, 0, 1,       "coll_overlap_1px");
        expect_at(125, K_COL, 0, 0,       "coll_touch_left_side");
        expect_at(126, K_COL, 0, 1,       "coll_overlap_left_1px");
        expect_at(127, K_COL, 0, 0,       "coll_touch_top");
        expect_at(128, K_COL, 0, 1,       "coll_overlap_top_1px");
        expect_at(129, K_COL, 0, 0,       "coll_clear");
        expect_at(240, K_ACT, 0, 4'b0001, "slot1_not_yet");
        expect_at(241, K_ACT, 0, 4'b0011, "slot1_spawn");
        expect_at(241, K_X,   1, 130,     "slot1_x");
        expect_at(363, K_X,   0, 614,     "near_right_edge");
        expect_at(363, K_COL, 0, 1,       "coll_wide_box_no_wrap");
        expect_at(364, K_X,   0, 615,     "clamp_right_edge");
        expect_at(364, K_Y,   0, 114,     "fall_start_y");
        expect_at(364, K_COL, 0, 0,       "coll_clear2");
        expect_at(365, K_X,   0, 615,     "fall_x_held");
        expect_at(365, K_Y,   0, 117,     "fall_y1");
        expect_at(366, K_Y,   0, 120,     "fall_y2");
        expect_at(383, K_Y,   0, 171,     "fall_y_last");
        expect_at(384, K_Y,   0, 174,     "land_tier1");
        expect_at(385, K_X,   0, 613,     "roll_left_x1");
        expect_at(386, K_X,   0, 611,     "roll_left_x2");
        expect_at(480, K_ACT, 0, 4'b0111, "three_active");
        expect_at(481, K_ACT, 0, 4'b1111, "four_active");
        expect_at(678, K_X,   0, 27,      "near_left_edge");
        expect_at(679, K_X,   0, 25,      "clamp_left_edge");
        expect_at(699, K_Y,   0, 234,     "land_tier2");
        expect_at(1644, K_Y,  0, 414,     "land_tier5");
        expect_at(1938, K_X,  0, 27,      "tier5_exit_x");
        expect_at(1939, K_ACT, 0, 4'b1110, "slot0_retired");
        expect_at(1940, K_ACT, 0, 4'b1111, "respawn_next_frame");
        expect_at(1940, K_X,   0, 130,     "respawn_x");
        expect_at(2059, K_ACT, 0, 4'b1101, "slot1_retired");
        expect_at(2060, K_ACT, 0, 4'b1111, "slot1_respawn");
        expect_at(2070, K_COL, 0, 1,       "coll_before_pause");
        expect_at(2070, K_X,   0, 390,     "x_before_pause");
        expect_at(2071, K_COL, 0, 0,       "coll_forced_paused");
        expect_at(2071, K_X,   0, 390,     "x_frozen1");
        expect_at(2073, K_X,   0, 390,     "x_frozen3");
        expect_at(2073, K_ACT, 0, 4'b1111, "active_frozen");
        expect_at(2074, K_ACT, 0, 4'b0000, "resume_clears");
        expect_at(2074, K_COL, 0, 0,       "resume_coll");
        expect_at(2075, K_COL, 0, 0,       "after_resume_coll");
        expect_at(2193, K_ACT, 0, 4'b0000, "no_spawn_after_resume");
        expect_at(2194, K_ACT, 0, 4'b0001, "spawn_after_resume");
        expect_at(2194, K_X,   0, 130,     "spawn_after_resume_x");
        expect_at(2195, K_COL, 0, 1,       "coll_before_reset");
        // async reset mid-cycle, checked before the next rising edge
        expect_reset_state();
        expect_at(120, K_ACT, 0, 4'b0000, "counter_cleared_by_reset");
        expect_at(121, K_ACT, 0, 4'b0001, "spawn_after_reset");

        // ---- stimulus ----
        repeat (3) @(negedge frame_clk);
        #1 Reset = 1'b1;

        wait_frame(121); set_ball(140, 114, 16);
        wait_frame(122); BallX = 10'd148;
        wait_frame(123); BallX = 10'd147;
        wait_frame(124); BallX = 10'd120;
        wait_frame(125); BallX = 10'd123;
        wait_frame(126); BallX = 10'd142; BallY = 10'd98;
        wait_frame(127); BallY = 10'd99;
        wait_frame(128); set_ball(0, 0, 1);
        wait_frame(362); set_ball(600, 100, 500);
        wait_frame(363); set_ball(0, 0, 1);
        wait_frame(2069); set_ball(390, 114, 16);
        wait_frame(2070); paused = 1'b1;
        wait_frame(2073); paused = 1'b0;
        wait_frame(2194); set_ball(140, 114, 16);
        wait_frame(2195);
        @(posedge frame_clk);
        #3 Reset = 1'b0;
        repeat (2) @(negedge frame_clk);
        #1 Reset = 1'b1;
        wait_frame(125);

        while (sb.size() > 0) begin
            m_e = sb.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s (frame %0d): never checked, expected %0d", m_e.name, m_e.frame, m_e.val);
        end
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #80000;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL watchdog: got timeout at frame %0d, expected test completion", frame_cnt);
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

endmodule
